touch_adc_responder: RTL and testbench

TOUCH_ADC_RESPONDER -- requirements
Module: touch_adc_responder

---
 rtl/touch_adc_responder.sv | 228 ++++++++++++++++++++++
 tb/tb_touch_adc_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_responder.sv
// touch_adc_responder: ADS7843-style touch ADC emulator on a 3-wire serial bus.
// The master's touch_clk/touch_csb/touch_din are oversampled in the cclk domain.
// Each pin passes through a SYNC_STAGES-deep synchronizer (legal depth 2..3).
// Edges of the synchronized serial clock then drive a four-state FSM.
// Optional feature: define TOUCH_RESP_PENIRQ_EN to add the penirqb pen-down output.
module touch_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        touch_clk,
  input  logic        touch_csb,
  input  logic        touch_din,
  output logic        touch_dout,
  output logic        touch_busy,
  input  logic [11:0] x_val,
  input  logic [11:0] y_val,
  input  logic [11:0] z_val,
  output logic [7:0]  last_cmd,
  output logic        cmd_done
`ifdef TOUCH_RESP_PENIRQ_EN
  ,
  output logic        penirqb
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    BUSY = 2'd2,
    DATA = 2'd3
  } state_t;

  // Synchronizer chains; index 0 is the stage nearest the pin.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] csb_sync_reg;
  logic [SYNC_STAGES-1:0] din_sync_reg;

  logic clk_s;
  logic csb_s;
  logic din_s;
  logic clk_prev_reg;
  logic rise;
  logic fall;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [6:0]  shift_reg, shift_next;
  logic [11:0] result_reg, result_next;
  logic        dout_reg, dout_next;
  logic        busy_reg, busy_next;
  logic [7:0]  last_cmd_reg, last_cmd_next;
  logic        cmd_done_reg, cmd_done_next;

  logic [7:0]  cmd_word;
  logic [11:0] sel_val;
  logic [11:0] captured;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      // One synchronizer stage per pin; idle-bus values on reset
      always_ff @(posedge cclk) begin
        if (!rstb) begin
          clk_sync_reg[gi] <= 1'b0;
          csb_sync_reg[gi] <= 1'b1;
          din_sync_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          clk_sync_reg[gi] <= touch_clk;
          csb_sync_reg[gi] <= touch_csb;
          din_sync_reg[gi] <= touch_din;
        end else begin
          clk_sync_reg[gi] <= clk_sync_reg[(gi > 0) ? gi - 1 : 0];
          csb_sync_reg[gi] <= csb_sync_reg[(gi > 0) ? gi - 1 : 0];
          din_sync_reg[gi] <= din_sync_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  assign clk_s = clk_sync_reg[SYNC_STAGES-1];
  assign csb_s = csb_sync_reg[SYNC_STAGES-1];
  assign din_s = din_sync_reg[SYNC_STAGES-1];

  // Remember the previous synchronized serial clock for edge detection
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      clk_prev_reg <= 1'b0;
    end else begin
      clk_prev_reg <= clk_s;
    end
  end

  assign rise = clk_s & ~clk_prev_reg;
  assign fall = ~clk_s & clk_prev_reg;

  // Full command word as it stands when the current din bit is appended
  assign cmd_word = {shift_reg, din_s};

  // Channel mux and 8/12-bit mode applied to the command being completed
  always_comb begin
    sel_val = 12'h000;
    case (cmd_word[6:4])
      3'b101:  sel_val = x_val;
      3'b001:  sel_val = y_val;
      3'b011:  sel_val = z_val;
      default: sel_val = 12'h000;
    endcase
    captured = cmd_word[3] ? {sel_val[11:4], 4'b0000} : sel_val;
  end

  // State and datapath registers
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 7'd0;
      result_reg   <= 12'h000;
      dout_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      last_cmd_reg <= 8'h00;
      cmd_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      result_reg   <= result_next;
      dout_reg     <= dout_next;
      busy_reg     <= busy_next;
      last_cmd_reg <= last_cmd_next;
      cmd_done_reg <= cmd_done_next;
    end
  end

  // Next-state logic: deselect dominates, din used on rises, outputs move on falls
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    result_next   = result_reg;
    dout_next     = dout_reg;
    busy_next     = busy_reg;
    last_cmd_next = last_cmd_reg;
    cmd_done_next = 1'b0;

    if (csb_s) begin
      state_next   = IDLE;
      dout_next    = 1'b0;
      busy_next    = 1'b0;
      bit_cnt_next = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Leading zero bits are ignored until a start bit arrives
          if (rise && din_s) begin
            state_next   = CMD;
            bit_cnt_next = 4'd1;
            shift_next   = 7'b000_0001;
          end
        end
        CMD: begin
          if (rise) begin
            shift_next   = cmd_word[6:0];
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              // Eighth bit: command complete, freeze the conversion result now
              last_cmd_next = cmd_word;
              cmd_done_next = 1'b1;
              result_next   = captured;
              bit_cnt_next  = 4'd0;
              state_next    = BUSY;
            end
          end
        end
        BUSY: begin
          if (fall) begin
            if (!busy_reg) begin
              busy_next = 1'b1;
            end else begin
              busy_next    = 1'b0;
              dout_next    = result_reg[11];
              result_next  = {result_reg[10:0], 1'b0};
              bit_cnt_next = 4'd11;
              state_next   = DATA;
            end
          end
        end
        DATA: begin
          if (fall) begin
            if (bit_cnt_reg != 4'd0) begin
              dout_next    = result_reg[11];
              result_next  = {result_reg[10:0], 1'b0};
              bit_cnt_next = bit_cnt_reg - 4'd1;
            end else begin
              // One fall past D0: return the line low and wait for a new command
              dout_next  = 1'b0;
              state_next = IDLE;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign touch_dout = dout_reg;
  assign touch_busy = busy_reg;
  assign last_cmd   = last_cmd_reg;
  assign cmd_done   = cmd_done_reg;

`ifdef TOUCH_RESP_PENIRQ_EN
  logic penirq_reg;

  // Pen-down indication: asserted low only while idle with a nonzero pressure reading
  always_ff @(posedge cclk) begin
    if (!rstb) begin
      penirq_reg <= 1'b1;
    end else begin
      penirq_reg <= !((state_reg == IDLE) && (z_val != 12'h000));
    end
  end

  assign penirqb = penirq_reg;
`endif

endmodule

// File: tb/tb_touch_adc_responder.sv
// tb_touch_adc_responder: drives the touch bus as a master and compares every
// returned bit against a reference computed from the command/channel rules.
module tb_touch_adc_responder;

  localparam int SYNC = 2;
  localparam int H    = 8;   // cclk cycles per touch_clk half period

  logic        cclk = 1'b0;
  logic        rstb;
  logic        touch_clk;
  logic        touch_csb;
  logic        touch_din;
  logic        touch_dout;
  logic        touch_busy;
  logic [11:0] x_val;
  logic [11:0] y_val;
  logic [11:0] z_val;
  logic [7:0]  last_cmd;
  logic        cmd_done;
`ifdef TOUCH_RESP_PENIRQ_EN
  logic        penirqb;
`endif

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int txn_no = 0;

  always #5 cclk = ~cclk;

  touch_adc_responder #(.SYNC_STAGES(SYNC)) dut (
    .cclk       (cclk),
    .rstb       (rstb),
    .touch_clk  (touch_clk),
    .touch_csb  (touch_csb),
    .touch_din  (touch_din),
    .touch_dout (touch_dout),
    .touch_busy (touch_busy),
    .x_val      (x_val),
    .y_val      (y_val),
    .z_val      (z_val),
    .last_cmd   (last_cmd),
    .cmd_done   (cmd_done)
`ifdef TOUCH_RESP_PENIRQ_EN
    ,
    .penirqb    (penirqb)
`endif
  );

  // Count cycles on which cmd_done is high (a clean pulse adds exactly one)
  always @(negedge cclk) begin
    if (cmd_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cc(input int n);
    repeat (n) @(posedge cclk);
    #1;
  endtask

  // Reference: channel rules and 8-bit truncation, straight from the command fields
  function automatic logic [11:0] model_result(input logic [7:0] cmd, input logic [11:0] x,
                                               input logic [11:0] y, input logic [11:0] z);
    logic [11:0] v;
    if (cmd[6:4] == 3'b101)      v = x;
    else if (cmd[6:4] == 3'b001) v = y;
    else if (cmd[6:4] == 3'b011) v = z;
    else                         v = 12'h000;
    if (cmd[3]) v = v & 12'hFF0;
    return v;
  endfunction

  task automatic send_bit(input logic b);
    touch_din = b;
    wait_cc(H);
    touch_clk = 1'b1;
    wait_cc(H);
    touch_clk = 1'b0;
  endtask

  // Sample the responder at the end of the low phase, then clock once more
  task automatic read_bit(output logic d, output logic bz);
    wait_cc(H);
    d  = touch_dout;
    bz = touch_busy;
    touch_clk = 1'b1;
    wait_cc(H);
    touch_clk = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int lead, input bit perturb);
    logic [11:0] exp_res;
    logic [11:0] got_res;
    logic        d;
    logic        bz;
    int          start_cnt;
    txn_no++;
    exp_res = model_result(cmd, x_val, y_val, z_val);
    got_res = 12'h000;
    touch_csb = 1'b0;
    wait_cc(H);
    start_cnt = done_cnt;
    for (int i = 0; i < lead; i++) send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    read_bit(d, bz);
    check($sformatf("t%0d busy_on", txn_no), {31'd0, bz}, 32'd1);
    check($sformatf("t%0d dout_in_busy", txn_no), {31'd0, d}, 32'd0);
`ifdef TOUCH_RESP_PENIRQ_EN
    check($sformatf("t%0d penirqb_busy", txn_no), {31'd0, penirqb}, 32'd1);
`endif
    if (perturb) begin
      x_val = 12'($urandom());
      y_val = 12'($urandom());
      z_val = 12'($urandom());
    end
    for (int i = 11; i >= 0; i--) begin
      read_bit(d, bz);
      got_res[i] = d;
      check($sformatf("t%0d busy_d%0d", txn_no, i), {31'd0, bz}, 32'd0);
    end
    check($sformatf("t%0d result", txn_no), {20'd0, got_res}, {20'd0, exp_res});
    read_bit(d, bz);
    check($sformatf("t%0d dout_tail", txn_no), {31'd0, d}, 32'd0);
    check($sformatf("t%0d busy_tail", txn_no), {31'd0, bz}, 32'd0);
    touch_csb = 1'b1;
    touch_din = 1'b0;
    wait_cc(H);
    check($sformatf("t%0d last_cmd", txn_no), {24'd0, last_cmd}, {24'd0, cmd});
    check($sformatf("t%0d cmd_done_cycles", txn_no), done_cnt - start_cnt, 32'd1);
    $display("txn %0d cmd=%02h lead=%0d perturb=%0d result=%03h expected=%03h",
             txn_no, cmd, lead, perturb, got_res, exp_res);
  endtask

  initial begin
    logic        d;
    logic        bz;
    logic [31:0] r;
    logic [2:0]  ch;
    logic [7:0]  cmd;
    int          start_cnt;

    rstb = 1'b0;
    touch_clk = 1'b0;
    touch_csb = 1'b1;
    touch_din = 1'b0;
    x_val = 12'h000;
    y_val = 12'h000;
    z_val = 12'h000;
    wait_cc(3);
    check("reset dout", {31'd0, touch_dout}, 32'd0);
    check("reset busy", {31'd0, touch_busy}, 32'd0);
    check("reset last_cmd", {24'd0, last_cmd}, 32'd0);
    check("reset cmd_done", {31'd0, cmd_done}, 32'd0);
`ifdef TOUCH_RESP_PENIRQ_EN
    check("reset penirqb", {31'd0, penirqb}, 32'd1);
`endif
    rstb = 1'b1;
    wait_cc(4);

    // Directed reads: X full scale, Y 8-bit mode, Z behind leading zeros, unused channel
    x_val = 12'hA5C;
    run_txn(8'hD0, 0, 1'b0);
    y_val = 12'h3F7;
    run_txn(8'h98, 0, 1'b0);
    z_val = 12'h801;
    run_txn(8'hB0, 3, 1'b0);
    x_val = 12'h5A5;
    run_txn(8'hE0, 0, 1'b1);

    // Deselect after five data bits: outputs must drop within SYNC+2 cycles
    x_val = 12'hFFF;
    touch_csb = 1'b0;
    wait_cc(H);
    cmd = 8'hD0;
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    read_bit(d, bz);
    for (int i = 0; i < 5; i++) begin
      read_bit(d, bz);
      check($sformatf("abort pre d%0d", 11 - i), {31'd0, d}, 32'd1);
    end
    touch_csb = 1'b1;
    wait_cc(SYNC + 2);
    check("abort dout", {31'd0, touch_dout}, 32'd0);
    check("abort busy", {31'd0, touch_busy}, 32'd0);
    $display("txn abort cmd=d0 deselected after 5 data bits");
    wait_cc(H);
    y_val = 12'h6C3;
    run_txn(8'h90, 0, 1'b0);

    // Reset in the middle of the data phase aborts the read
    z_val = 12'hFFF;
    touch_csb = 1'b0;
    wait_cc(H);
    cmd = 8'hB0;
    for (int i = 7; i >= 0; i--) send_bit(cmd[i]);
    read_bit(d, bz);
    read_bit(d, bz);
    read_bit(d, bz);
    rstb = 1'b0;
    wait_cc(1);
    check("midreset dout", {31'd0, touch_dout}, 32'd0);
    check("midreset busy", {31'd0, touch_busy}, 32'd0);
    check("midreset last_cmd", {24'd0, last_cmd}, 32'd0);
    check("midreset cmd_done", {31'd0, cmd_done}, 32'd0);
    rstb = 1'b1;
    touch_din = 1'b0;
    start_cnt = done_cnt;
    for (int i = 0; i < 6; i++) begin
      read_bit(d, bz);
      check($sformatf("postreset dout%0d", i), {31'd0, d}, 32'd0);
      check($sformatf("postreset busy%0d", i), {31'd0, bz}, 32'd0);
    end
    check("postreset no cmd_done", done_cnt - start_cnt, 32'd0);
    touch_csb = 1'b1;
    wait_cc(H);
    $display("txn midreset cmd=b0 reset during data phase");
    z_val = 12'h123;
    run_txn(8'hB0, 1, 1'b0);

`ifdef TOUCH_RESP_PENIRQ_EN
    z_val = 12'h010;
    wait_cc(3);
    check("penirqb pen down", {31'd0, penirqb}, 32'd0);
    z_val = 12'h000;
    wait_cc(3);
    check("penirqb pen up", {31'd0, penirqb}, 32'd1);
`endif

    // Randomized reads across all channels and modes
    for (int n = 0; n < 24; n++) begin
      r = $urandom();
      case (r[1:0])
        2'd0:    ch = 3'b101;
        2'd1:    ch = 3'b001;
        2'd2:    ch = 3'b011;
        default: ch = r[4:2];
      endcase
      cmd = {1'b1, ch, r[5], r[8:6]};
      x_val = 12'($urandom());
      y_val = 12'($urandom());
      z_val = 12'($urandom());
      run_txn(cmd, int'(r[10:9]) % 4, r[11]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
